keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 20 ++
 rtl/keypad_debounce.sv | 126 ++++++++++++
 rtl/keypad_scanner.sv | 136 +++++++++++++
 tb/tb_keypad_scanner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the key-map constant for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} deb_state_e;

  typedef enum logic [1:0] {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_kind_e;

  // Nibble i holds the code for {row, col} == i (Pmod KYPD layout).
  localparam logic [63:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [3:0] idx);
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Press/release debounce FSM stepped once per full keypad scan.
// Build option KEYPAD_REPEAT_EN adds auto-repeat events while a key stays held.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_SCANS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_done,
  input  scan_kind_e scan_kind,
  input  logic [3:0] scan_code,
  output logic       evt_valid,
  output logic [3:0] evt_code,
  output logic       key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       cand_q, cand_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_SCANS + 1);
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
`else
  logic rpt_unused;
  assign rpt_unused = (REPEAT_SCANS == 0);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    evt_valid = 1'b0;
    cnt_inc   = cnt_q + CNT_ONE;
`ifdef KEYPAD_REPEAT_EN
    rpt_d     = rpt_q;
    rpt_inc   = rpt_q + RPT_W'(1);
`endif
    if (scan_done) begin
      case (state_q)
        IDLE: begin
          if (scan_kind == SCAN_SINGLE) begin
            cand_d = scan_code;
            cnt_d  = CNT_ONE;
            if (CNT_ONE >= CNT_MAX) begin
              state_d   = HELD;
              evt_valid = 1'b1;
            end else begin
              state_d = PRESS_DEB;
            end
          end
        end
        PRESS_DEB: begin
          if (scan_kind == SCAN_SINGLE && scan_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              state_d   = HELD;
              evt_valid = 1'b1;
            end
          end else if (scan_kind == SCAN_SINGLE) begin
            cand_d = scan_code;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (scan_kind == SCAN_NONE) begin
            cnt_d   = CNT_ONE;
            state_d = (CNT_ONE >= CNT_MAX) ? IDLE : RELEASE_DEB;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rpt_inc >= RPT_W'(REPEAT_SCANS)) begin
            rpt_d     = '0;
            evt_valid = 1'b1;
          end else begin
            rpt_d = rpt_inc;
          end
`endif
        end
        RELEASE_DEB: begin
          if (scan_kind == SCAN_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) state_d = IDLE;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    // Repeat timing restarts from every fresh press; a release bounce keeps it.
    if (state_d == IDLE || state_d == PRESS_DEB) rpt_d = '0;
`endif
  end

  assign evt_code = cand_d;
  assign key_held = (state_q == HELD) || (state_q == RELEASE_DEB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchronizer, column strobing, scan classification, event delivery.
// Build option KEYPAD_REPEAT_EN enables auto-repeat in keypad_debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_SCANS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       hit_cnt_q, hit_cnt_d;
  logic [3:0]       hit_code_q, hit_code_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             overflow_q, overflow_d;

  logic             sample, scan_done;
  logic [2:0]       col_hits, total_hits;
  logic [1:0]       hit_row, merged_cnt;
  logic [3:0]       col_code, merged_code;
  scan_kind_e       scan_kind;
  logic             evt_valid;
  logic [3:0]       evt_code;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign col[gi] = (col_idx_q != 2'(gi));
    end
  endgenerate

  // Hits accumulate across the four columns; counts saturate at 2 (= multi).
  always_comb begin
    col_hits = '0;
    hit_row  = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_q[r]) begin
        col_hits = col_hits + 3'd1;
        hit_row  = 2'(r);
      end
    end
    col_code    = key_lookup({hit_row, col_idx_q});
    total_hits  = {1'b0, hit_cnt_q} + col_hits;
    merged_cnt  = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
    merged_code = (hit_cnt_q == 2'd0) ? col_code : hit_code_q;
    scan_kind   = (merged_cnt == 2'd0) ? SCAN_NONE :
                  (merged_cnt == 2'd1) ? SCAN_SINGLE : SCAN_MULTI;

    sample    = (div_q == DIV_LAST);
    scan_done = sample && (col_idx_q == 2'd3);
    div_d     = sample ? '0 : div_q + DIV_W'(1);
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;

    hit_cnt_d  = hit_cnt_q;
    hit_code_d = hit_code_q;
    if (sample) begin
      hit_cnt_d  = scan_done ? 2'd0 : merged_cnt;
      hit_code_d = scan_done ? 4'd0 : merged_code;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_SCANS (REPEAT_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_done (scan_done),
    .scan_kind (scan_kind),
    .scan_code (merged_code),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .key_held  (key_held)
  );

  // An unaccepted event is never overwritten; a newcomer is dropped and flagged.
  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overflow_d  = overflow_q;
    if (evt_valid) begin
      if (!key_valid_q || key_ready) begin
        key_valid_d = 1'b1;
        key_code_d  = evt_code;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      div_q       <= '0;
      col_idx_q   <= '0;
      hit_cnt_q   <= '0;
      hit_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      row_meta_q  <= row;
      row_sync_q  <= row_meta_q;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      hit_cnt_q   <= hit_cnt_d;
      hit_code_q  <= hit_code_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overflow_q  <= overflow_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scan table plus randomized presses against a run-length model.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
`ifdef KEYPAD_REPEAT_EN
  localparam int RPT      = 3;
`else
  localparam int RPT      = 64;
`endif
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;
  logic       overflow;

  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int scan_no = 0;

  // Bench's own picture of the keypad: index row*4+col.
  logic [3:0] tb_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  // Reference state: length of the current run of identical scan results.
  int         run_kind, run_len, prev_kind, m_rpt, m_events;
  logic [3:0] run_code;
  bit         m_held, m_valid, m_ovf;
  logic [3:0] m_code;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEB),
    .REPEAT_SCANS (RPT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (scan %0d)", name, act, req, scan_no);
    end
  endtask

  task automatic model_reset();
    run_kind = -1; run_len = 0; prev_kind = 0; m_rpt = 0;
    m_held = 0; m_valid = 0; m_ovf = 0; m_code = 4'h0;
  endtask

  task automatic model_scan(input logic [15:0] mask, input logic rdy);
    int n, kind;
    logic [3:0] code;
    bit evt;
    n = $countones(mask);
    code = 4'h0;
    for (int i = 0; i < 16; i++) if (mask[i]) code = tb_map[i];
    kind = (n == 0) ? 0 : (n == 1) ? 1 : 2;
    if (kind == run_kind && (kind != 1 || code == run_code)) run_len++;
    else begin run_kind = kind; run_code = code; run_len = 1; end
    evt = 0;
    if (!m_held) begin
      if (kind == 1 && run_len == DEB) begin evt = 1; m_held = 1; m_rpt = 0; end
    end else if (kind == 0) begin
      if (run_len == DEB) m_held = 0;
    end else if (prev_kind != 0) begin
`ifdef KEYPAD_REPEAT_EN
      m_rpt++;
      if (m_rpt == RPT) begin evt = 1; m_rpt = 0; end
`endif
    end
    prev_kind = kind;
    if (m_valid && rdy) m_valid = 0;
    if (evt) begin
      m_events++;
      if (!m_valid) begin m_valid = 1; m_code = run_code; end
      else m_ovf = 1;
    end
  endtask

  task automatic do_scan(input logic [15:0] mask, input logic rdy);
    pressed = mask;
    key_ready = rdy;
    repeat (SCAN_CYC) @(posedge clk);
    #1;
    scan_no++;
    model_scan(mask, rdy);
    $display("scan %0d mask=%04h rdy=%0b -> valid=%0b code=%h held=%0b ovf=%0b",
             scan_no, mask, rdy, key_valid, key_code, key_held, overflow);
  endtask

  task automatic chk_model();
    chk("valid", key_valid, m_valid);
    chk("code", key_code, m_code);
    chk("held", key_held, m_held);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("rst_col", col, 4'b1110);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_code", key_code, 4'h0);
    chk("rst_held", key_held, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
  endtask

  typedef struct {
    logic [15:0] mask;
    logic        rdy;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic        exp_held;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  localparam logic [15:0] K6 = 16'h0040, K9 = 16'h0400, K1 = 16'h0001, K5 = 16'h0020;
  localparam logic [15:0] K3 = 16'h0004, KA = 16'h0008, KD = 16'h8000;

  initial begin
    // single press of 6, release
    vecs.push_back('{K6, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{K6, 1'b1, 1'b1, 4'h6, 1'b1, 1'b0});
    vecs.push_back('{K6, 1'b1, 1'b0, 4'h6, 1'b1, 1'b0});
    vecs.push_back('{K6, 1'b1, 1'b0, 4'h6, 1'b1, 1'b0});
`ifdef KEYPAD_REPEAT_EN
    vecs.push_back('{K6, 1'b1, 1'b1, 4'h6, 1'b1, 1'b0});
`else
    vecs.push_back('{K6, 1'b1, 1'b0, 4'h6, 1'b1, 1'b0});
`endif
    vecs.push_back('{16'h0, 1'b1, 1'b0, 4'h6, 1'b1, 1'b0});
    vecs.push_back('{16'h0, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0});
    // bouncing 9
    vecs.push_back('{K9, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0});
    vecs.push_back('{16'h0, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0});
    vecs.push_back('{K9, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0});
    vecs.push_back('{K9, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0});
    vecs.push_back('{16'h0, 1'b1, 1'b0, 4'h9, 1'b1, 1'b0});
    vecs.push_back('{16'h0, 1'b1, 1'b0, 4'h9, 1'b0, 1'b0});
    // 1 and 5 together, then only 1
    vecs.push_back('{K1 | K5, 1'b1, 1'b0, 4'h9, 1'b0, 1'b0});
    vecs.push_back('{K1 | K5, 1'b1, 1'b0, 4'h9, 1'b0, 1'b0});
    vecs.push_back('{K1, 1'b1, 1'b0, 4'h9, 1'b0, 1'b0});
    vecs.push_back('{K1, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0});
    vecs.push_back('{16'h0, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0});
    vecs.push_back('{16'h0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0});
    // backpressure: 3 then A with the consumer stalled
    vecs.push_back('{K3, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0});
    vecs.push_back('{K3, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0});
    vecs.push_back('{16'h0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0});
    vecs.push_back('{16'h0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0});
    vecs.push_back('{KA, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0});
    vecs.push_back('{KA, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1});
    vecs.push_back('{16'h0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1});

    m_events = 0;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("col_step", col, 4'b1101);
    repeat (12) @(posedge clk);
    #1;
    chk("col_wrap", col, 4'b1110);
    model_scan(16'h0, 1'b0);

    foreach (vecs[i]) begin
      do_scan(vecs[i].mask, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), key_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_code", i), key_code, vecs[i].exp_code);
      chk($sformatf("vec%0d_held", i), key_held, vecs[i].exp_held);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
    end

    // One-cycle accept of the stalled event, then finish the release scan.
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    key_ready = 1'b0;
    chk("accept_valid", key_valid, 1'b0);
    chk("accept_code", key_code, 4'h3);
    m_valid = 0;
    repeat (SCAN_CYC - 1) @(posedge clk);
    #1;
    scan_no++;
    model_scan(16'h0, 1'b0);
    chk("after_accept_held", key_held, 1'b0);
    chk("after_accept_ovf", overflow, 1'b1);

    // Reset in the middle of a scan with an event pending.
    do_scan(K6, 1'b0);
    do_scan(K6, 1'b0);
    chk("pre_reset_valid", key_valid, 1'b1);
    pressed = '0;
    repeat (5) @(posedge clk);
    do_reset();

`ifdef KEYPAD_REPEAT_EN
    m_events = 0;
    for (int s = 0; s < 10; s++) begin
      do_scan(KD, 1'b1);
      chk_model();
    end
    chk("repeat_events", m_events, 3);
    chk("repeat_code", key_code, 4'hD);
    do_scan(16'h0, 1'b1);
    do_scan(16'h0, 1'b1);
    chk_model();
`endif

    // Randomized segments: hold a mask for a few scans, consumer ready at random.
    for (int seg = 0; seg < 30; seg++) begin
      logic [15:0] mask;
      int pick, len;
      pick = $urandom_range(0, 9);
      if (pick < 3) mask = '0;
      else if (pick < 9) mask = 16'h1 << (4 * $urandom_range(0, 2) + $urandom_range(0, 1));
      else mask = (16'h1 << $urandom_range(0, 7)) | (16'h1 << $urandom_range(8, 15));
      len = $urandom_range(1, 4);
      for (int s = 0; s < len; s++) begin
        do_scan(mask, ($urandom_range(0, 3) != 0));
        chk_model();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
